// File: rtl/anubis_pkg.sv
// Shared Anubis constants, the key-reverser state type and a GF(2^8) doubling helper.
package anubis_pkg;

  localparam int ANUBIS_BLOCK_W   = 128;
  localparam int ANUBIS_MAX_RKEYS = 19;
  localparam int ANUBIS_RIDX_W    = 5;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } keyrev_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    gf_xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
  endfunction

endpackage

// File: rtl/anubis_decrypt_key_reverser_if.sv
// Key-stream bus for the decryption key reverser; the flush signal exists only with
// ANUBIS_KEYREV_FLUSH_EN defined.
interface anubis_decrypt_key_reverser_if;
  import anubis_pkg::*;

  // Handshakes: a word moves on a rising edge where valid and ready are both high;
  // valid never depends on ready, and payload holds stable while valid waits on ready.
  logic                      in_valid;
  logic                      in_ready;
  logic [ANUBIS_BLOCK_W-1:0] in_key;
  logic                      out_valid;
  logic                      out_ready;
  logic [ANUBIS_BLOCK_W-1:0] out_key;
  logic [ANUBIS_RIDX_W-1:0]  out_round;
  logic                      out_last;
  logic                      busy;
  keyrev_state_e             dbg_state;
`ifdef ANUBIS_KEYREV_FLUSH_EN
  logic                      flush;
`endif

  modport slave (
    input  in_valid, in_key, out_ready,
`ifdef ANUBIS_KEYREV_FLUSH_EN
    input  flush,
`endif
    output in_ready, out_valid, out_key, out_round, out_last, busy, dbg_state
  );

  modport master (
    output in_valid, in_key, out_ready,
`ifdef ANUBIS_KEYREV_FLUSH_EN
    output flush,
`endif
    input  in_ready, out_valid, out_key, out_round, out_last, busy, dbg_state
  );

endinterface

// File: rtl/Anubis_Theta_Function.sv
// Anubis theta: each 4-byte row of the 4x4 state is multiplied by had(01,02,04,06) over GF(2^8).
module Anubis_Theta_Function
  import anubis_pkg::*;
(
  input  logic [ANUBIS_BLOCK_W-1:0] data_i,
  output logic [ANUBIS_BLOCK_W-1:0] data_o
);

  function automatic logic [31:0] theta_row(input logic [31:0] row);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x6 [4];
    for (int k = 0; k < 4; k++) begin
      a[k]  = row[31-8*k -: 8];
      x2[k] = gf_xtime(a[k]);
      x4[k] = gf_xtime(x2[k]);
      x6[k] = x2[k] ^ x4[k];
    end
    // Column j picks coefficient h[k^j] for row byte k, h = {01,02,04,06}.
    theta_row = {a[0]  ^ x2[1] ^ x4[2] ^ x6[3],
                 x2[0] ^ a[1]  ^ x6[2] ^ x4[3],
                 x4[0] ^ x6[1] ^ a[2]  ^ x2[3],
                 x6[0] ^ x4[1] ^ x2[2] ^ a[3]};
  endfunction

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign data_o[ANUBIS_BLOCK_W-1-32*r -: 32] = theta_row(data_i[ANUBIS_BLOCK_W-1-32*r -: 32]);
  end

endmodule

// File: rtl/anubis_decrypt_key_reverser.sv
// Buffers one set of encryption round keys and replays it reversed as decryption round keys.
// Optional ANUBIS_KEYREV_FLUSH_EN adds a flush input that abandons the current set.
module anubis_decrypt_key_reverser
  import anubis_pkg::*;
#(
  parameter int NUM_RKEYS = 13
) (
  input logic clk,
  input logic rst,
  anubis_decrypt_key_reverser_if.slave bus
);

  localparam int AW = $clog2(NUM_RKEYS);
  localparam logic [ANUBIS_RIDX_W-1:0] LAST_IDX   = ANUBIS_RIDX_W'(NUM_RKEYS - 1);
  localparam logic [ANUBIS_RIDX_W-1:0] PENULT_IDX = ANUBIS_RIDX_W'(NUM_RKEYS - 2);

  keyrev_state_e             state_q;
  logic [ANUBIS_RIDX_W-1:0]  wr_cnt_q;
  logic [ANUBIS_RIDX_W-1:0]  rd_idx_q;
  logic [ANUBIS_RIDX_W-1:0]  out_round_q;
  logic                      out_valid_q;
  logic                      out_last_q;
  logic [ANUBIS_BLOCK_W-1:0] out_key_q;
  logic [ANUBIS_BLOCK_W-1:0] out_key_d;
  logic [ANUBIS_BLOCK_W-1:0] mem_q [NUM_RKEYS];
  logic [ANUBIS_BLOCK_W-1:0] rd_raw;
  logic [ANUBIS_BLOCK_W-1:0] rd_theta;
  logic                      abandon;
  logic                      in_fire;
  logic                      out_fire;

`ifdef ANUBIS_KEYREV_FLUSH_EN
  assign abandon = rst | bus.flush;
`else
  assign abandon = rst;
`endif

  assign in_fire  = (state_q == LOAD) & bus.in_valid;
  assign out_fire = out_valid_q & bus.out_ready;

  // Buffer is not reset; a write only happens while loading.
  always_ff @(posedge clk) begin
    if (in_fire && !abandon) begin
      mem_q[wr_cnt_q[AW-1:0]] <= bus.in_key;
    end
  end

  // rd_idx_q already points at the key for the next round; K0 leaves the buffer unmodified.
  assign rd_raw = mem_q[rd_idx_q[AW-1:0]];

  Anubis_Theta_Function u_theta (
    .data_i (rd_raw),
    .data_o (rd_theta)
  );

  assign out_key_d = (rd_idx_q == '0) ? rd_raw : rd_theta;

  always_ff @(posedge clk) begin
    if (abandon) begin
      state_q     <= LOAD;
      wr_cnt_q    <= '0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_key_q   <= '0;
      out_round_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_fire) begin
            if (wr_cnt_q == LAST_IDX) begin
              // The final key goes straight out as K'0 while it is also written to the buffer.
              state_q     <= DRAIN;
              wr_cnt_q    <= '0;
              rd_idx_q    <= PENULT_IDX;
              out_valid_q <= 1'b1;
              out_key_q   <= bus.in_key;
              out_round_q <= '0;
              out_last_q  <= 1'b0;
            end else begin
              wr_cnt_q <= wr_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_last_q) begin
              state_q     <= LOAD;
              rd_idx_q    <= '0;
              out_valid_q <= 1'b0;
              out_round_q <= '0;
              out_last_q  <= 1'b0;
            end else begin
              out_key_q   <= out_key_d;
              out_round_q <= out_round_q + 1'b1;
              out_last_q  <= ((out_round_q + 1'b1) == LAST_IDX);
              if (rd_idx_q != '0) begin
                rd_idx_q <= rd_idx_q - 1'b1;
              end
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_key   = out_key_q;
  assign bus.out_round = out_round_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = (state_q == DRAIN) | (wr_cnt_q != '0);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_anubis_decrypt_key_reverser.sv
// Self-checking bench for anubis_decrypt_key_reverser (13- and 19-key instances).
module tb_anubis_decrypt_key_reverser;
  import anubis_pkg::*;

  localparam int N   = 13;
  localparam int N19 = 19;
  localparam int W   = ANUBIS_BLOCK_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  logic flush13;
  int   vectors = 0;
  int   miscompares = 0;

  anubis_decrypt_key_reverser_if bus13 ();
  anubis_decrypt_key_reverser_if bus19 ();

  anubis_decrypt_key_reverser #(.NUM_RKEYS(N)) dut13 (
    .clk (clk),
    .rst (rst),
    .bus (bus13)
  );

  anubis_decrypt_key_reverser #(.NUM_RKEYS(N19)) dut19 (
    .clk (clk),
    .rst (rst),
    .bus (bus19)
  );

`ifdef ANUBIS_KEYREV_FLUSH_EN
  assign flush13 = bus13.flush;
`else
  assign flush13 = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011D << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [W-1:0] theta_m(input logic [W-1:0] x);
    logic [7:0]   h [4];
    logic [7:0]   a [4][4];
    logic [7:0]   b;
    logic [W-1:0] y;
    h[0] = 8'h01; h[1] = 8'h02; h[2] = 8'h04; h[3] = 8'h06;
    for (int n = 0; n < 16; n++) a[n/4][n%4] = x[W-1-8*n -: 8];
    y = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'h00;
        for (int k = 0; k < 4; k++) b ^= gmul(a[i][k], h[k ^ j]);
        y[W-1-8*(4*i+j) -: 8] = b;
      end
    end
    return y;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard model (13-key instance) ----------------
  logic [W-1:0] acc_q[$];
  logic [W-1:0] exp_q[$];

  always @(posedge clk) begin
    if (rst || flush13) begin
      acc_q.delete();
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      if (bus13.out_ready) void'(exp_q.pop_front());
    end else if (bus13.in_valid) begin
      acc_q.push_back(bus13.in_key);
      if (acc_q.size() == N) begin
        exp_q.push_back(acc_q[N-1]);
        for (int r = 1; r < N - 1; r++) exp_q.push_back(theta_m(acc_q[N-1-r]));
        exp_q.push_back(acc_q[0]);
        acc_q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready", W'(bus13.in_ready), W'(exp_q.size() == 0));
      check("out_valid", W'(bus13.out_valid), W'(exp_q.size() != 0));
      check("busy", W'(bus13.busy), W'((acc_q.size() != 0) || (exp_q.size() != 0)));
      if (exp_q.size() != 0) begin
        check("out_key", bus13.out_key, exp_q[0]);
        check("out_round", W'(bus13.out_round), W'(N - exp_q.size()));
        check("out_last", W'(bus13.out_last), W'(exp_q.size() == 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [W-1:0] keys[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] ref1[$];

  task automatic set_keys(input int mode);
    keys.delete();
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       keys.push_back(W'(i));
        1:       keys.push_back((i == 1) ? W'(1) : W'(0));
        default: keys.push_back({$urandom, $urandom, $urandom, $urandom});
      endcase
    end
  endtask

  task automatic load_keys(input int count, input bit gaps);
    int i = 0;
    int guard = 0;
    bit hs;
    while (i < count && guard < 400) begin
      bus13.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus13.in_key   = keys[i];
      hs = bus13.in_valid && bus13.in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      guard++;
    end
    bus13.in_valid = 1'b0;
    check("load_done", W'(i), W'(count));
  endtask

  task automatic drain_set(input bit rand_ready, input int stall_round, input bit junk_in);
    int guard = 0;
    int stalls = 0;
    bit done = 1'b0;
    bit hs;
    got_q.delete();
    while (!done && guard < 200) begin
      if (stall_round >= 0 && bus13.out_valid && int'(bus13.out_round) == stall_round && stalls < 3) begin
        bus13.out_ready = 1'b0;
        stalls++;
      end else begin
        bus13.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (junk_in) begin
        bus13.in_valid = 1'b1;
        bus13.in_key   = {$urandom, $urandom, $urandom, $urandom};
      end
      hs = bus13.out_valid && bus13.out_ready;
      if (hs) got_q.push_back(bus13.out_key);
      if (hs && bus13.out_last) done = 1'b1;
      @(posedge clk); #1;
      guard++;
    end
    bus13.out_ready = 1'b0;
    bus13.in_valid  = 1'b0;
    check("drain_done", W'(done), W'(1));
    check("drain_count", W'(got_q.size()), W'(N));
  endtask

  task automatic compare_ref1(input string name);
    for (int i = 0; i < N; i++) begin
      check(name, (i < got_q.size()) ? got_q[i] : 'x, ref1[i]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] k19[$];
    logic [W-1:0] e19;
    bus13.in_valid = 1'b0; bus13.in_key = '0; bus13.out_ready = 1'b0;
    bus19.in_valid = 1'b0; bus19.in_key = '0; bus19.out_ready = 1'b0;
`ifdef ANUBIS_KEYREV_FLUSH_EN
    bus13.flush = 1'b0;
    bus19.flush = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_key", bus13.out_key, W'(0));
    check("rst_out_round", W'(bus13.out_round), W'(0));
    check("rst_out_last", W'(bus13.out_last), W'(0));
    check("rst_out_valid", W'(bus13.out_valid), W'(0));
    check("rst_in_ready", W'(bus13.in_ready), W'(1));
    check("rst_busy", W'(bus13.busy), W'(0));
    chk_en = 1'b1;

    // Ascending keys, consumer always ready.
    set_keys(0);
    load_keys(N, 1'b0);
    drain_set(1'b0, -1, 1'b0);
    check("t1_first", got_q[0], W'(128'h0C));
    check("t1_last", got_q[N-1], W'(0));
    ref1 = got_q;

    // Single unit byte in K1.
    set_keys(1);
    load_keys(N, 1'b0);
    drain_set(1'b0, -1, 1'b0);
    check("t2_theta_unit", got_q[11], W'(128'h06040201));

    // Backpressure at round 5.
    set_keys(0);
    load_keys(N, 1'b1);
    drain_set(1'b0, 5, 1'b0);
    compare_ref1("t3_stall_seq");

    // Input traffic during drain is ignored.
    set_keys(0);
    load_keys(N, 1'b0);
    drain_set(1'b1, -1, 1'b1);
    compare_ref1("t4_junk_seq");

    // Reset in the middle of a load.
    set_keys(2);
    load_keys(6, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_busy_after_rst", W'(bus13.busy), W'(0));
    check("t5_ready_after_rst", W'(bus13.in_ready), W'(1));
    set_keys(2);
    load_keys(N, 1'b1);
    drain_set(1'b1, -1, 1'b0);

    // Random sets with random gaps and backpressure.
    for (int s = 0; s < 4; s++) begin
      set_keys(2);
      load_keys(N, 1'b1);
      drain_set(1'b1, -1, 1'b0);
    end

`ifdef ANUBIS_KEYREV_FLUSH_EN
    begin
      int guard = 0;
      set_keys(2);
      load_keys(N, 1'b0);
      bus13.out_ready = 1'b1;
      while (!(bus13.out_valid && bus13.out_round == 5'd4) && guard < 40) begin
        @(posedge clk); #1;
        guard++;
      end
      check("t7_reach_round4", W'(bus13.out_round), W'(4));
      bus13.flush = 1'b1;
      @(posedge clk); #1;
      bus13.flush = 1'b0;
      bus13.out_ready = 1'b0;
      check("t7_out_valid", W'(bus13.out_valid), W'(0));
      check("t7_in_ready", W'(bus13.in_ready), W'(1));
      check("t7_busy", W'(bus13.busy), W'(0));
      set_keys(2);
      load_keys(N, 1'b1);
      drain_set(1'b1, -1, 1'b0);
    end
`endif

    // 19-key instance: latency of the first output and position of out_last.
    for (int i = 0; i < N19; i++) k19.push_back({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < N19; i++) begin
      check("t6_in_ready", W'(bus19.in_ready), W'(1));
      check("t6_no_early_valid", W'(bus19.out_valid), W'(0));
      bus19.in_valid = 1'b1;
      bus19.in_key   = k19[i];
      @(posedge clk); #1;
    end
    bus19.in_valid  = 1'b0;
    bus19.out_ready = 1'b1;
    check("t6_first_valid", W'(bus19.out_valid), W'(1));
    for (int r = 0; r < N19; r++) begin
      if (r == 0)            e19 = k19[N19-1];
      else if (r == N19 - 1) e19 = k19[0];
      else                   e19 = theta_m(k19[N19-1-r]);
      check("t6_key", bus19.out_key, e19);
      check("t6_round", W'(bus19.out_round), W'(r));
      check("t6_last", W'(bus19.out_last), W'(r == N19 - 1));
      @(posedge clk); #1;
    end
    bus19.out_ready = 1'b0;
    check("t6_done_valid", W'(bus19.out_valid), W'(0));
    check("t6_done_ready", W'(bus19.in_ready), W'(1));

    chk_en = 1'b0;
    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
